i2s_tx_serializer: RTL and testbench
====================================

Name: i2s_tx_serializer

Overview:
- Downstream consumer of the front-end PCM source (triangle test generator or later sample path). Captures the 24-bit left/right samples and their single-cycle valid strobes.
- Serializes them as a standard Philips I2S stream (BCLK, LRCLK, SDATA) toward the DAC.
- BCLK and LRCLK are derived from the 49.152 MHz mclk by clock-enable division. No second clock domain.
- Default settings give 64 BCLK per frame at 48 kHz.

Parameters:
- DATA_BITS, 24, PCM sample width; MSB sent first.
- SLOT_BITS, 32, BCLK periods per channel slot; must be >= DATA_BITS+1.
- BCLK_DIV, 8, clk cycles per BCLK half-period. Fs = clk / (4*BCLK_DIV*SLOT_BITS).

Ports:
- clk  in  1  master clock (mclk, 49.152 MHz).
- reset  in  1  asynchronous, active-high reset.
- run  in  1  enable; 0 holds block idle (synchronous clear).
- l_dout_valid  in  1  one-cycle strobe; l_pcm_data valid.
- r_dout_valid  in  1  one-cycle strobe; r_pcm_data valid.
- l_pcm_data  in  DATA_BITS  left sample, two's complement.
- r_pcm_data  in  DATA_BITS  right sample, two's complement.
- bclk  out  1  I2S bit clock, registered.
- lrclk  out  1  I2S word select, 0=left, 1=right, registered.
- sdata  out  1  I2S serial data, registered.
- frame_start  out  1  one-cycle strobe at each frame load.
- underrun  out  1  sticky: a frame was loaded without fresh data.
- overrun  out  1  sticky: a sample was overwritten before transmission.

Behaviour:
- Clocking/reset: one clock (clk). Reset is asynchronous and active-high.
- Reset or run=0 clears all state:
  - bclk=0, lrclk=0, sdata=0, frame_start=0, underrun=0, overrun=0.
  - div_cnt=0, bit_cnt=2*SLOT_BITS-1.
  - Hold registers=0, l_pend=0, r_pend=0.
- BCLK divider:
  - div_cnt counts 0..BCLK_DIV-1 while run=1.
  - At terminal count, bclk toggles and div_cnt wraps to 0.
  - A toggle 1->0 is a "fall event"; a toggle 0->1 is a "rise event".
  - First rise event occurs BCLK_DIV cycles after run goes high; first fall event after 2*BCLK_DIV cycles.
- Bit counter: increments mod 2*SLOT_BITS on each fall event only.
- All of the following update in the same clk cycle as a fall event, using the new bit_cnt value k:
  - lrclk = (k >= SLOT_BITS).
  - Slot bit index j = (k mod SLOT_BITS) - 1.
  - sdata = frame sample bit (DATA_BITS-1-j) when 0 <= j < DATA_BITS; otherwise 0. This gives the I2S one-bit delay plus zero padding.
  - Left slot uses frame_l; right slot uses frame_r.
- Frame load, on the fall event where k wraps to 0:
  - frame_l <= hold_l, frame_r <= hold_r.
  - frame_start=1 for that cycle only.
  - If l_pend=0 or r_pend=0, underrun <= 1 and the previous hold value is repeated.
  - l_pend and r_pend are cleared.
- Capture:
  - l_dout_valid: hold_l <= l_pcm_data, l_pend <= 1.
  - r_dout_valid: hold_r <= r_pcm_data, r_pend <= 1.
  - L and R are independent; both strobes in the same cycle are allowed.
- Overrun:
  - Set when a strobe arrives with its pend flag already 1 and no frame load in that cycle.
  - Latest value wins.
- Strobe coinciding with frame load:
  - The frame takes the OLD hold value.
  - The hold register takes the new value and pend ends at 1 (set beats clear).
  - No overrun; no underrun from that channel if its pend was already 1 before the cycle.
- Sticky flags clear only on reset or run=0.
- run falling mid-frame: all outputs go to 0 on the next clk edge; the partial frame is discarded. A subsequent run=1 restarts from the first-frame timing above.
- Strobes are ignored while run=0.
- Latency: a sample captured before a frame load has its MSB on sdata 1 BCLK after that frame load for left, and SLOT_BITS+1 BCLK after it for right.

Test Plan:
1. Reset behaviour: assert reset asynchronously mid-frame with bclk=1 → all outputs 0 immediately, with no clk edge needed; release, run=1 → first frame_start exactly 16 clk cycles later.
2. Basic frame: strobe L=0xA5A5A5 and R=0x5A5A5A before the first load → after the load:
   - sdata=0 for k=0, then bits 101001011010010110100101 for k=1..24, then 0 for k=25..31.
   - lrclk rises at k=32; right-slot pattern is 010110100101101001011010.
   - Frame period is 1024 clk.
3. Underrun: supply only the first frame's data → second frame repeats 0xA5A5A5/0x5A5A5A, underrun=1 from the second frame_start; overrun stays 0.
4. Overrun: two l_dout_valid strobes (0x111111, then 0x7FFFFF) within one frame → overrun=1; next frame left slot carries 0x7FFFFF.
5. Coincident load: l_dout_valid with L=0x000001 in the frame_start cycle, while hold_l=0x800000 and pend=1 → current frame sends 0x800000, next frame sends 0x000001, overrun=0.
6. run drop: run=0 at k=40 → bclk/lrclk/sdata=0 next clk and flags cleared; run=1 again → clean restart, first frame_start after 16 cycles, underrun=1 at that load because no data was captured.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// Philips I2S transmitter: captures strobed 24-bit L/R PCM samples and serializes
// them as BCLK/LRCLK/SDATA, with both bit clocks derived from mclk by clock enables.
module i2s_tx_serializer #(
  parameter int DATA_BITS = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_DIV  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 l_dout_valid,
  input  logic                 r_dout_valid,
  input  logic [DATA_BITS-1:0] l_pcm_data,
  input  logic [DATA_BITS-1:0] r_pcm_data,
  output logic                 bclk,
  output logic                 lrclk,
  output logic                 sdata,
  output logic                 frame_start,
  output logic                 underrun,
  output logic                 overrun
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] SLOT_K   = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0] DATA_LIM = BIT_W'(DATA_BITS);

  logic [DIV_W-1:0]     div_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic                 bclk_r, lrclk_r, sdata_r, frame_start_r, underrun_r, overrun_r;
  logic [DATA_BITS-1:0] hold_l_r, hold_r_r, frame_l_r, frame_r_r;
  logic                 l_pend_r, r_pend_r;

  logic                 tick_s, fall_s, load_s, ser_bit_s;
  logic [BIT_W-1:0]     bit_next_s, slot_pos_s;
  logic [DATA_BITS-1:0] frame_sel_s, shifted_s;

  // Divider terminal count, next bit position and the data bit for that position.
  always_comb begin
    tick_s      = 1'b0;
    fall_s      = 1'b0;
    load_s      = 1'b0;
    bit_next_s  = '0;
    slot_pos_s  = '0;
    frame_sel_s = '0;
    shifted_s   = '0;
    ser_bit_s   = 1'b0;

    tick_s = (div_cnt_r == DIV_LAST);
    fall_s = tick_s && bclk_r;
    if (bit_cnt_r == BIT_LAST) begin
      bit_next_s = '0;
    end else begin
      bit_next_s = bit_cnt_r + 1'b1;
    end
    load_s = fall_s && (bit_next_s == '0);

    if (bit_next_s >= SLOT_K) begin
      slot_pos_s  = bit_next_s - SLOT_K;
      frame_sel_s = frame_r_r;
    end else begin
      slot_pos_s  = bit_next_s;
      frame_sel_s = frame_l_r;
    end

    // Slot position 0 is the I2S one-bit delay; positions past the sample are padding.
    if ((slot_pos_s != '0) && (slot_pos_s <= DATA_LIM)) begin
      shifted_s = frame_sel_s << (slot_pos_s - 1'b1);
      ser_bit_s = shifted_s[DATA_BITS-1];
    end else begin
      ser_bit_s = 1'b0;
    end
  end

  // Clock-enable divider, serializer, frame load and sample capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_r     <= '0;
      bit_cnt_r     <= BIT_LAST;
      bclk_r        <= 1'b0;
      lrclk_r       <= 1'b0;
      sdata_r       <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      overrun_r     <= 1'b0;
      hold_l_r      <= '0;
      hold_r_r      <= '0;
      frame_l_r     <= '0;
      frame_r_r     <= '0;
      l_pend_r      <= 1'b0;
      r_pend_r      <= 1'b0;
    end else if (!run) begin
      div_cnt_r     <= '0;
      bit_cnt_r     <= BIT_LAST;
      bclk_r        <= 1'b0;
      lrclk_r       <= 1'b0;
      sdata_r       <= 1'b0;
      frame_start_r <= 1'b0;
      underrun_r    <= 1'b0;
      overrun_r     <= 1'b0;
      hold_l_r      <= '0;
      hold_r_r      <= '0;
      frame_l_r     <= '0;
      frame_r_r     <= '0;
      l_pend_r      <= 1'b0;
      r_pend_r      <= 1'b0;
    end else begin
      if (tick_s) begin
        div_cnt_r <= '0;
        bclk_r    <= ~bclk_r;
      end else begin
        div_cnt_r <= div_cnt_r + 1'b1;
      end

      frame_start_r <= load_s;

      if (fall_s) begin
        bit_cnt_r <= bit_next_s;
        lrclk_r   <= (bit_next_s >= SLOT_K);
        sdata_r   <= ser_bit_s;
      end

      if (load_s) begin
        frame_l_r <= hold_l_r;
        frame_r_r <= hold_r_r;
        if (!l_pend_r || !r_pend_r) begin
          underrun_r <= 1'b1;
        end
      end

      // A strobe landing on the load cycle refills the hold and keeps pend set.
      if (l_dout_valid) begin
        hold_l_r <= l_pcm_data;
        l_pend_r <= 1'b1;
        if (l_pend_r && !load_s) begin
          overrun_r <= 1'b1;
        end
      end else if (load_s) begin
        l_pend_r <= 1'b0;
      end

      if (r_dout_valid) begin
        hold_r_r <= r_pcm_data;
        r_pend_r <= 1'b1;
        if (r_pend_r && !load_s) begin
          overrun_r <= 1'b1;
        end
      end else if (load_s) begin
        r_pend_r <= 1'b0;
      end
    end
  end

  assign bclk        = bclk_r;
  assign lrclk       = lrclk_r;
  assign sdata       = sdata_r;
  assign frame_start = frame_start_r;
  assign underrun    = underrun_r;
  assign overrun     = overrun_r;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Bench for i2s_tx_serializer: a deserializing monitor checks every completed frame
// against a queue of expected L/R words; flags and timing are checked inline.
module tb_i2s_tx_serializer;

  logic        clk;
  logic        reset;
  logic        run;
  logic        l_dout_valid, r_dout_valid;
  logic [23:0] l_pcm_data, r_pcm_data;
  logic        bclk, lrclk, sdata, frame_start, underrun, overrun;

  i2s_tx_serializer #(.DATA_BITS(24), .SLOT_BITS(32), .BCLK_DIV(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .l_dout_valid (l_dout_valid),
    .r_dout_valid (r_dout_valid),
    .l_pcm_data   (l_pcm_data),
    .r_pcm_data   (r_pcm_data),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .frame_start  (frame_start),
    .underrun     (underrun),
    .overrun      (overrun)
  );

  typedef struct packed {
    logic [23:0] l;
    logic [23:0] r;
  } frame_t;

  typedef struct {
    bit          do_l;
    logic [23:0] l_a;
    bit          do_l2;
    logic [23:0] l_b;
    bit          do_r;
    logic [23:0] r_a;
    logic [23:0] exp_l;
    logic [23:0] exp_r;
    bit          exp_under;
    bit          exp_over;
  } vec_t;

  frame_t sb_q[$];
  vec_t   vecs[4];
  int     n_checks = 0;
  int     n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [23:0] l, input logic [23:0] r);
    frame_t f;
    f.l = l;
    f.r = r;
    sb_q.push_back(f);
  endtask

  function automatic logic [5:0] outs();
    return {bclk, lrclk, sdata, frame_start, underrun, overrun};
  endfunction

  // Monitor: rebuild each frame from sdata sampled on BCLK rising edges.
  bit          cap_active = 1'b0;
  bit          prev_bclk  = 1'b0;
  bit          pad_bad, lr_bad;
  int          cap_idx;
  logic [23:0] cap_l, cap_r;
  frame_t      exp_f;

  always @(negedge clk) begin
    if (reset || !run) begin
      cap_active = 1'b0;
      prev_bclk  = 1'b0;
    end else begin
      if (frame_start) begin
        cap_active = 1'b1;
        cap_idx    = 0;
        cap_l      = '0;
        cap_r      = '0;
        pad_bad    = 1'b0;
        lr_bad     = 1'b0;
      end
      if (cap_active && bclk && !prev_bclk) begin
        if (lrclk !== (cap_idx >= 32)) lr_bad = 1'b1;
        if (cap_idx >= 1 && cap_idx <= 24) cap_l = {cap_l[22:0], sdata};
        else if (cap_idx >= 33 && cap_idx <= 56) cap_r = {cap_r[22:0], sdata};
        else if (sdata !== 1'b0) pad_bad = 1'b1;
        cap_idx++;
        if (cap_idx == 64) begin
          cap_active = 1'b0;
          check("sb_pending", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            exp_f = sb_q.pop_front();
            check("frame_left", 32'(cap_l), 32'(exp_f.l));
            check("frame_right", 32'(cap_r), 32'(exp_f.r));
            check("pad_bits", 32'(pad_bad), 32'd0);
            check("lrclk_pattern", 32'(lr_bad), 32'd0);
          end
        end
      end
      prev_bclk = bclk;
    end
  end

  // Called on the negedge where frame_start is seen; ends on the next frame_start negedge.
  task automatic frame_stim(input bit do_l, input logic [23:0] la, input bit do_l2,
                            input logic [23:0] lb, input bit do_r, input logic [23:0] ra,
                            input bit coin_l, input logic [23:0] lc);
    for (int c = 1; c < 1024; c++) begin
      @(negedge clk);
      l_dout_valid = 1'b0;
      r_dout_valid = 1'b0;
      if (c == 1) check("frame_start_pulse", 32'(frame_start), 32'd0);
      if (c == 100 && do_l) begin l_dout_valid = 1'b1; l_pcm_data = la; end
      if (c == 100 && do_r) begin r_dout_valid = 1'b1; r_pcm_data = ra; end
      if (c == 300 && do_l2) begin l_dout_valid = 1'b1; l_pcm_data = lb; end
      if (c == 1023 && coin_l) begin l_dout_valid = 1'b1; l_pcm_data = lc; end
    end
    @(negedge clk);
    l_dout_valid = 1'b0;
    r_dout_valid = 1'b0;
    check("frame_period", 32'(frame_start), 32'd1);
  endtask

  // Counts negedges from run rising until frame_start, bounded.
  task automatic count_to_start(output int cnt, input bit load_data);
    bit found = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 64 && !found; c++) begin
      @(negedge clk);
      cnt = c;
      l_dout_valid = 1'b0;
      r_dout_valid = 1'b0;
      if (c == 3 && load_data) begin
        l_dout_valid = 1'b1; l_pcm_data = 24'hA5A5A5;
        r_dout_valid = 1'b1; r_pcm_data = 24'h5A5A5A;
        push_exp(24'hA5A5A5, 24'h5A5A5A);
      end
      if (c == 7) check("pre_rise_bclk", 32'(bclk), 32'd0);
      if (c == 8) check("first_rise_bclk", 32'(bclk), 32'd1);
      if (frame_start) found = 1'b1;
    end
  endtask

  initial begin
    int  cnt;
    bit  found;

    vecs[0] = '{do_l:1'b1, l_a:24'h123456, do_l2:1'b0, l_b:24'h0, do_r:1'b1, r_a:24'hFEDCBA,
                exp_l:24'h123456, exp_r:24'hFEDCBA, exp_under:1'b1, exp_over:1'b0};
    vecs[1] = '{do_l:1'b1, l_a:24'h800000, do_l2:1'b0, l_b:24'h0, do_r:1'b1, r_a:24'h7FFFFF,
                exp_l:24'h800000, exp_r:24'h7FFFFF, exp_under:1'b1, exp_over:1'b0};
    vecs[2] = '{do_l:1'b1, l_a:24'h111111, do_l2:1'b1, l_b:24'h7FFFFF, do_r:1'b1, r_a:24'h000000,
                exp_l:24'h7FFFFF, exp_r:24'h000000, exp_under:1'b1, exp_over:1'b1};
    vecs[3] = '{do_l:1'b0, l_a:24'h0, do_l2:1'b0, l_b:24'h0, do_r:1'b1, r_a:24'hABCDEF,
                exp_l:24'h7FFFFF, exp_r:24'hABCDEF, exp_under:1'b1, exp_over:1'b1};

    reset = 1'b1; run = 1'b0;
    l_dout_valid = 1'b0; r_dout_valid = 1'b0;
    l_pcm_data = '0; r_pcm_data = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outs()), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_outputs", 32'(outs()), 32'd0);

    // Cold start without data, then async reset while bclk is high mid-frame.
    run = 1'b1;
    count_to_start(cnt, 1'b0);
    check("cold_first_frame_start", 32'(cnt), 32'd16);
    check("cold_underrun", 32'(underrun), 32'd1);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bclk) found = 1'b1;
    end
    check("bclk_high_wait", 32'(found), 32'd1);
    #2 reset = 1'b1; run = 1'b0;
    #1 check("async_reset_outputs", 32'(outs()), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0; run = 1'b1;

    // Frame 1 carries A5A5A5/5A5A5A; frame 2 repeats it as an underrun.
    count_to_start(cnt, 1'b1);
    check("first_frame_start", 32'(cnt), 32'd16);
    check("first_no_underrun", 32'(underrun), 32'd0);
    push_exp(24'hA5A5A5, 24'h5A5A5A);
    frame_stim(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 24'h0);
    check("underrun_repeat", 32'(underrun), 32'd1);
    check("no_overrun_repeat", 32'(overrun), 32'd0);

    // Strobe on the load cycle: frame takes old hold, the next frame the new value.
    push_exp(24'h800000, 24'h0F0F0F);
    push_exp(24'h000001, 24'h0F0F0F);
    frame_stim(1'b1, 24'h800000, 1'b0, 24'h0, 1'b1, 24'h0F0F0F, 1'b1, 24'h000001);
    check("coincident_overrun", 32'(overrun), 32'd0);
    frame_stim(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 24'h0);
    check("coincident_overrun_next", 32'(overrun), 32'd0);

    for (int i = 0; i < 4; i++) begin
      push_exp(vecs[i].exp_l, vecs[i].exp_r);
      frame_stim(vecs[i].do_l, vecs[i].l_a, vecs[i].do_l2, vecs[i].l_b,
                 vecs[i].do_r, vecs[i].r_a, 1'b0, 24'h0);
      check($sformatf("vec%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_under));
      check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'(vecs[i].exp_over));
    end

    // Let the last table frame finish; the one after it is dropped at k=40.
    frame_stim(1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 24'h0, 1'b0, 24'h0);
    repeat (640) @(negedge clk);
    check("lrclk_right_slot", 32'(lrclk), 32'd1);
    check("overrun_before_drop", 32'(overrun), 32'd1);
    run = 1'b0;
    @(negedge clk);
    check("run_drop_clear", 32'(outs()), 32'd0);
    l_dout_valid = 1'b1; l_pcm_data = 24'h333333;
    r_dout_valid = 1'b1; r_pcm_data = 24'h333333;
    @(negedge clk);
    l_dout_valid = 1'b0; r_dout_valid = 1'b0;
    @(negedge clk);
    run = 1'b1;
    push_exp(24'h000000, 24'h000000);
    count_to_start(cnt, 1'b0);
    check("restart_frame_start", 32'(cnt), 32'd16);
    check("restart_underrun", 32'(underrun), 32'd1);
    check("restart_overrun", 32'(overrun), 32'd0);

    found = 1'b0;
    for (int c = 0; c < 1100 && !found; c++) begin
      @(negedge clk);
      if (sb_q.size() == 0) found = 1'b1;
    end
    check("scoreboard_drain", 32'(found), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
